// File: rtl/vec_alu_sequencer.sv
// Instruction-side sequencer for the vector lane ALU: accepts one vector instruction,
// streams element reads from the register file and writes ALU results/predicates back.
module vec_alu_sequencer #(
    parameter int WIDTH  = 32,
    parameter int REG_W  = 5,
    parameter int MAX_VL = 16,
    parameter int IDX_W  = $clog2(MAX_VL)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [3:0]             instr_op,
    input  logic [REG_W-1:0]       instr_vd,
    input  logic [REG_W-1:0]       instr_vs1,
    input  logic [REG_W-1:0]       instr_vs2,
    input  logic                   instr_use_scalar,
    input  logic [WIDTH-1:0]       instr_scalar,
    input  logic [IDX_W:0]         instr_vl,
    input  logic                   instr_masked,
    input  logic [MAX_VL-1:0]      instr_mask,
    output logic                   rf_rd_en,
    output logic [REG_W+IDX_W-1:0] rf_rd_addr_a,
    output logic [REG_W+IDX_W-1:0] rf_rd_addr_b,
    output logic [WIDTH-1:0]       alu_c,
    output logic                   alu_mux_control,
    output logic                   alu_add_sub,
    output logic [2:0]             alu_output_control,
    output logic [1:0]             alu_bitwise_control,
    output logic [1:0]             alu_comp_control,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_predicate,
    output logic                   rf_wr_en,
    output logic [REG_W+IDX_W-1:0] rf_wr_addr,
    output logic [WIDTH-1:0]       rf_wr_data,
    output logic                   pred_wr_en,
    output logic [IDX_W-1:0]       pred_wr_idx,
    output logic                   pred_wr_bit,
    output logic                   done,
    output logic                   illegal
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [IDX_W:0]   MAX_VL_L = (IDX_W+1)'(MAX_VL);
    localparam logic [IDX_W:0]   VL_ZERO  = {(IDX_W+1){1'b0}};
    localparam logic [IDX_W:0]   VL_ONE   = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    // Packed ALU control word: {output_control[2:0], add_sub, bitwise[1:0], comp[1:0]}
    function automatic logic [7:0] decode_op(input logic [3:0] op);
        logic [7:0] f;
        f = 8'h00;
        case (op)
            4'd0:    f = {3'b000, 1'b0, 2'b00, 2'b00};
            4'd1:    f = {3'b000, 1'b1, 2'b00, 2'b00};
            4'd2:    f = {3'b001, 1'b0, 2'b00, 2'b00};
            4'd3:    f = {3'b001, 1'b1, 2'b00, 2'b00};
            4'd4:    f = {3'b010, 1'b0, 2'b00, 2'b00};
            4'd5:    f = {3'b011, 1'b0, 2'b00, 2'b00};
            4'd6:    f = {3'b100, 1'b0, 2'b00, 2'b00};
            4'd7:    f = {3'b100, 1'b0, 2'b01, 2'b00};
            4'd8:    f = {3'b100, 1'b0, 2'b10, 2'b00};
            4'd9:    f = {3'b100, 1'b0, 2'b11, 2'b00};
            4'd10:   f = {3'b000, 1'b0, 2'b00, 2'b00};
            4'd11:   f = {3'b000, 1'b0, 2'b00, 2'b01};
            4'd12:   f = {3'b000, 1'b0, 2'b00, 2'b10};
            4'd13:   f = {3'b000, 1'b0, 2'b00, 2'b11};
            default: f = 8'h00;
        endcase
        return f;
    endfunction

    logic [1:0]             state_q, state_d;
    logic                   ready_q, ready_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W:0]         vl_q, vl_d;
    logic [REG_W-1:0]       vd_q, vd_d;
    logic [REG_W-1:0]       vs1_q, vs1_d;
    logic [REG_W-1:0]       vs2_q, vs2_d;
    logic                   masked_q, masked_d;
    logic [MAX_VL-1:0]      mask_q, mask_d;
    logic                   cmp_q, cmp_d;
    logic [7:0]             ctl_q, ctl_d;
    logic                   mux_q, mux_d;
    logic [WIDTH-1:0]       alu_c_q, alu_c_d;
    logic                   rd_en_q, rd_en_d;
    logic [REG_W+IDX_W-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [REG_W+IDX_W-1:0] rd_addr_b_q, rd_addr_b_d;
    logic                   wr_en_q, wr_en_d;
    logic [REG_W+IDX_W-1:0] wr_addr_q, wr_addr_d;
    logic                   pred_en_q, pred_en_d;
    logic [IDX_W-1:0]       pred_idx_q, pred_idx_d;
    logic                   done_q, done_d;
    logic                   illegal_q, illegal_d;

    logic [IDX_W:0]         vl_eff_s;
    logic                   op_illegal_s;
    logic                   op_cmp_s;
    logic                   last_elem_s;
    logic                   elem_en_s;
    logic [IDX_W-1:0]       idx_inc_s;

    assign vl_eff_s     = (instr_vl > MAX_VL_L) ? MAX_VL_L : instr_vl;
    assign op_illegal_s = (instr_op >= 4'd14);
    assign op_cmp_s     = (instr_op >= 4'd10) && (instr_op <= 4'd13);
    assign last_elem_s  = (({1'b0, idx_q} + VL_ONE) == vl_q);
    assign elem_en_s    = !masked_q || mask_q[idx_q];
    assign idx_inc_s    = idx_q + IDX_ONE;

    // Next-state logic: element sequencing plus the one-cycle-delayed write-back stage
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        idx_d       = idx_q;
        vl_d        = vl_q;
        vd_d        = vd_q;
        vs1_d       = vs1_q;
        vs2_d       = vs2_q;
        masked_d    = masked_q;
        mask_d      = mask_q;
        cmp_d       = cmp_q;
        ctl_d       = ctl_q;
        mux_d       = mux_q;
        alu_c_d     = alu_c_q;
        rd_en_d     = 1'b0;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        pred_en_d   = 1'b0;
        pred_idx_d  = pred_idx_q;
        done_d      = 1'b0;
        illegal_d   = 1'b0;

        // Data read this cycle arrives next cycle; the strobe follows it there
        if (rd_en_q) begin
            if (cmp_q) begin
                pred_en_d  = elem_en_s;
                pred_idx_d = idx_q;
            end else begin
                wr_en_d   = elem_en_s;
                wr_addr_d = {vd_q, idx_q};
            end
        end else begin
            wr_addr_d = wr_addr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (instr_valid && ready_q) begin
                    ready_d  = 1'b0;
                    vd_d     = instr_vd;
                    vs1_d    = instr_vs1;
                    vs2_d    = instr_vs2;
                    masked_d = instr_masked;
                    mask_d   = instr_mask;
                    cmp_d    = op_cmp_s;
                    ctl_d    = decode_op(instr_op);
                    mux_d    = instr_use_scalar;
                    alu_c_d  = instr_scalar;
                    vl_d     = vl_eff_s;
                    idx_d    = IDX_ZERO;
                    if (op_illegal_s) begin
                        state_d   = ST_DRAIN;
                        illegal_d = 1'b1;
                    end else if (vl_eff_s == VL_ZERO) begin
                        state_d = ST_DRAIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        rd_en_d     = 1'b1;
                        rd_addr_a_d = {instr_vs1, IDX_ZERO};
                        rd_addr_b_d = {instr_vs2, IDX_ZERO};
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (last_elem_s) begin
                    state_d = ST_DRAIN;
                    done_d  = 1'b1;
                end else begin
                    idx_d       = idx_inc_s;
                    rd_en_d     = 1'b1;
                    rd_addr_a_d = {vs1_q, idx_inc_s};
                    rd_addr_b_d = {vs2_q, idx_inc_s};
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            idx_q       <= IDX_ZERO;
            vl_q        <= VL_ZERO;
            vd_q        <= {REG_W{1'b0}};
            vs1_q       <= {REG_W{1'b0}};
            vs2_q       <= {REG_W{1'b0}};
            masked_q    <= 1'b0;
            mask_q      <= {MAX_VL{1'b0}};
            cmp_q       <= 1'b0;
            ctl_q       <= 8'h00;
            mux_q       <= 1'b0;
            alu_c_q     <= {WIDTH{1'b0}};
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= {(REG_W+IDX_W){1'b0}};
            rd_addr_b_q <= {(REG_W+IDX_W){1'b0}};
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {(REG_W+IDX_W){1'b0}};
            pred_en_q   <= 1'b0;
            pred_idx_q  <= IDX_ZERO;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            idx_q       <= idx_d;
            vl_q        <= vl_d;
            vd_q        <= vd_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            masked_q    <= masked_d;
            mask_q      <= mask_d;
            cmp_q       <= cmp_d;
            ctl_q       <= ctl_d;
            mux_q       <= mux_d;
            alu_c_q     <= alu_c_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            pred_en_q   <= pred_en_d;
            pred_idx_q  <= pred_idx_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
        end
    end

    assign instr_ready         = ready_q;
    assign rf_rd_en            = rd_en_q;
    assign rf_rd_addr_a        = rd_addr_a_q;
    assign rf_rd_addr_b        = rd_addr_b_q;
    assign alu_c               = alu_c_q;
    assign alu_mux_control     = mux_q;
    assign alu_output_control  = ctl_q[7:5];
    assign alu_add_sub         = ctl_q[4];
    assign alu_bitwise_control = ctl_q[3:2];
    assign alu_comp_control    = ctl_q[1:0];
    assign rf_wr_en            = wr_en_q;
    assign rf_wr_addr          = wr_addr_q;
    // ALU is combinational on registered RF data, so the result is passed through unregistered
    assign rf_wr_data          = wr_en_q ? alu_result : {WIDTH{1'b0}};
    assign pred_wr_en          = pred_en_q;
    assign pred_wr_idx         = pred_idx_q;
    assign pred_wr_bit         = pred_en_q ? alu_predicate : 1'b0;
    assign done                = done_q;
    assign illegal             = illegal_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Self-checking bench: register-file and ALU stand-ins plus a scoreboard of expected writes.
module tb_vec_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [4:0]  instr_vd, instr_vs1, instr_vs2;
    logic        instr_use_scalar;
    logic [31:0] instr_scalar;
    logic [4:0]  instr_vl;
    logic        instr_masked;
    logic [15:0] instr_mask;
    logic        rf_rd_en;
    logic [8:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [31:0] alu_c;
    logic        alu_mux_control, alu_add_sub;
    logic [2:0]  alu_output_control;
    logic [1:0]  alu_bitwise_control, alu_comp_control;
    logic [31:0] alu_result;
    logic        alu_predicate;
    logic        rf_wr_en;
    logic [8:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        pred_wr_en;
    logic [3:0]  pred_wr_idx;
    logic        pred_wr_bit;
    logic        done, illegal;

    vec_alu_sequencer dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2),
        .instr_use_scalar(instr_use_scalar), .instr_scalar(instr_scalar), .instr_vl(instr_vl),
        .instr_masked(instr_masked), .instr_mask(instr_mask),
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .alu_c(alu_c), .alu_mux_control(alu_mux_control), .alu_add_sub(alu_add_sub),
        .alu_output_control(alu_output_control), .alu_bitwise_control(alu_bitwise_control),
        .alu_comp_control(alu_comp_control), .alu_result(alu_result), .alu_predicate(alu_predicate),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .pred_wr_en(pred_wr_en), .pred_wr_idx(pred_wr_idx), .pred_wr_bit(pred_wr_bit),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // Cycle counter used to time-stamp expected events
    always @(posedge clk) cyc <= cyc + 1;

    // Register file stand-in: synchronous read, latency one
    logic [31:0] rf_mem [0:31][0:15];
    logic [31:0] rd_a_q, rd_b_q;
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rd_a_q <= rf_mem[rf_rd_addr_a[8:4]][rf_rd_addr_a[3:0]];
            rd_b_q <= rf_mem[rf_rd_addr_b[8:4]][rf_rd_addr_b[3:0]];
        end
    end

    // ALU stand-in driven purely by the DUT's control outputs
    logic [31:0] alu_b, alu_sum;
    always_comb begin
        alu_b   = alu_mux_control ? alu_c : rd_b_q;
        alu_sum = alu_add_sub ? (rd_a_q - alu_b) : (rd_a_q + alu_b);
        case (alu_output_control)
            3'b000:  alu_result = alu_sum;
            3'b001:  alu_result = alu_sum + 32'd1;
            3'b010:  alu_result = rd_a_q * alu_b;
            3'b011:  alu_result = rd_a_q * alu_b + 32'd7;
            3'b100: begin
                case (alu_bitwise_control)
                    2'b00:   alu_result = rd_a_q & alu_b;
                    2'b01:   alu_result = rd_a_q | alu_b;
                    2'b10:   alu_result = rd_a_q ^ alu_b;
                    default: alu_result = ~(rd_a_q | alu_b);
                endcase
            end
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        case (alu_comp_control)
            2'b00:   alu_predicate = (rd_a_q == alu_b);
            2'b01:   alu_predicate = (rd_a_q < alu_b);
            2'b10:   alu_predicate = (rd_a_q > alu_b);
            default: alu_predicate = (rd_a_q != alu_b);
        endcase
    end

    // Reference results straight from the opcode meaning
    function automatic logic [31:0] ref_val(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a + b + 32'd1;
            4'd3:    return a - b + 32'd1;
            4'd4:    return a * b;
            4'd5:    return a * b + 32'd7;
            4'd6:    return a & b;
            4'd7:    return a | b;
            4'd8:    return a ^ b;
            4'd9:    return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_pred(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd10:   return a == b;
            4'd11:   return a < b;
            4'd12:   return a > b;
            default: return a != b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    typedef struct { logic [8:0] addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { logic [3:0] idx; logic bitv; int cyc; } pr_t;
    wr_t wr_q[$];
    pr_t pr_q[$];

    // Scoreboard: every write strobe must match the next expected write, in the expected cycle
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_rf_wr", {55'd0, rf_wr_addr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("rf_wr_addr", rf_wr_addr, e.addr);
                chk("rf_wr_data", rf_wr_data, e.data);
                chk("rf_wr_cycle", cyc, e.cyc);
            end
        end
        if (pred_wr_en === 1'b1) begin
            if (pr_q.size() == 0) begin
                chk("unexpected_pred_wr", {60'd0, pred_wr_idx}, 64'hFFFF);
            end else begin
                pr_t p;
                p = pr_q.pop_front();
                chk("pred_wr_idx", pred_wr_idx, p.idx);
                chk("pred_wr_bit", pred_wr_bit, p.bitv);
                chk("pred_wr_cycle", cyc, p.cyc);
            end
        end
    end

    task automatic run_instr(input logic [3:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                             input logic [4:0] vs2, input logic us, input logic [31:0] sc,
                             input logic [4:0] vl, input logic msk, input logic [15:0] mask);
        int a, vle, endk, w;
        logic ill, cmp, exp_rd;
        logic [2:0] eo;
        logic eas;
        logic [1:0] ebw, ecmp;
        w = 0;
        while (instr_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_issue", instr_ready, 1'b1);
        instr_valid = 1'b1; instr_op = op; instr_vd = vd; instr_vs1 = vs1; instr_vs2 = vs2;
        instr_use_scalar = us; instr_scalar = sc; instr_vl = vl; instr_masked = msk; instr_mask = mask;
        a    = cyc;
        vle  = (vl > 5'd16) ? 16 : int'(vl);
        ill  = (op >= 4'd14);
        cmp  = (op >= 4'd10) && (op <= 4'd13);
        endk = (ill || vle == 0) ? 1 : vle + 1;
        eo   = (op <= 4'd1) ? 3'd0 : (op <= 4'd3) ? 3'd1 : (op == 4'd4) ? 3'd2 :
               (op == 4'd5) ? 3'd3 : (op <= 4'd9) ? 3'd4 : 3'd0;
        eas  = (op == 4'd1) || (op == 4'd3);
        ebw  = (op >= 4'd6 && op <= 4'd9) ? 2'(op - 4'd6) : 2'd0;
        ecmp = cmp ? 2'(op - 4'd10) : 2'd0;
        if (!ill) begin
            for (int i = 0; i < vle; i++) begin
                logic [31:0] av, bv;
                av = rf_mem[vs1][i];
                bv = us ? sc : rf_mem[vs2][i];
                if (!msk || mask[i]) begin
                    if (cmp) pr_q.push_back('{idx: 4'(i), bitv: ref_pred(op, av, bv), cyc: a + 2 + i});
                    else     wr_q.push_back('{addr: {vd, 4'(i)}, data: ref_val(op, av, bv), cyc: a + 2 + i});
                end
            end
        end
        for (int k = 1; k <= endk + 1; k++) begin
            @(negedge clk);
            exp_rd = !ill && (k <= vle);
            chk("instr_ready", instr_ready, k > endk);
            chk("done", done, !ill && (k == endk));
            chk("illegal", illegal, ill && (k == endk));
            chk("rf_rd_en", rf_rd_en, exp_rd);
            if (exp_rd) begin
                chk("rf_rd_addr_a", rf_rd_addr_a, {vs1, 4'(k - 1)});
                chk("rf_rd_addr_b", rf_rd_addr_b, {vs2, 4'(k - 1)});
            end
            if (k <= endk) begin
                chk("alu_output_control", alu_output_control, eo);
                chk("alu_add_sub", alu_add_sub, eas);
                chk("alu_bitwise_control", alu_bitwise_control, ebw);
                chk("alu_comp_control", alu_comp_control, ecmp);
                chk("alu_mux_control", alu_mux_control, us);
                chk("alu_c", alu_c, sc);
            end
            // Garbage offered while busy must be ignored
            instr_valid = (k < endk);
            instr_op = 4'($urandom_range(0, 15)); instr_vd = 5'($urandom_range(0, 31));
            instr_vs1 = 5'($urandom_range(0, 31)); instr_vs2 = 5'($urandom_range(0, 31));
            instr_scalar = $urandom; instr_vl = 5'($urandom_range(0, 31));
            instr_use_scalar = 1'($urandom_range(0, 1));
        end
        chk("rf_writes_outstanding", wr_q.size(), 0);
        chk("pred_writes_outstanding", pr_q.size(), 0);
    endtask

    initial begin
        int a;
        reset = 1'b1; instr_valid = 1'b0; instr_op = 4'd0; instr_vd = 5'd0; instr_vs1 = 5'd0;
        instr_vs2 = 5'd0; instr_use_scalar = 1'b0; instr_scalar = 32'd0; instr_vl = 5'd0;
        instr_masked = 1'b0; instr_mask = 16'd0;
        for (int r = 0; r < 32; r++)
            for (int e = 0; e < 16; e++)
                rf_mem[r][e] = $urandom;
        for (int e = 0; e < 4; e++) begin
            rf_mem[1][e] = 32'(e + 1);
            rf_mem[2][e] = 32'(10 * (e + 1));
        end
        rf_mem[6][0] = 32'd1; rf_mem[6][1] = 32'd5; rf_mem[6][2] = 32'd1;
        rf_mem[7][0] = 32'd2; rf_mem[7][1] = 32'd3; rf_mem[7][2] = 32'd2;

        repeat (3) @(negedge clk);
        chk("reset_ready", instr_ready, 1'b1);
        chk("reset_strobes", {rf_rd_en, rf_wr_en, pred_wr_en, done, illegal}, 5'd0);
        chk("reset_alu_ctl", {alu_mux_control, alu_add_sub, alu_output_control,
                              alu_bitwise_control, alu_comp_control}, 9'd0);
        chk("reset_alu_c", alu_c, 32'd0);
        chk("reset_addrs", {rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}, 27'd0);
        chk("reset_wr_data", rf_wr_data, 32'd0);
        reset = 1'b0;

        // VADD: 11,22,33,44 into v3
        run_instr(4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 5'd4, 1'b0, 16'h0000);
        chk("vadd_hand_value", ref_val(4'd0, rf_mem[1][3], rf_mem[2][3]), 32'd44);
        // VFSUB with scalar operand
        run_instr(4'd3, 5'd5, 5'd1, 5'd2, 1'b1, 32'h3F80_0000, 5'd2, 1'b0, 16'h0000);
        // VCMP1 giving predicates 1,0,1
        run_instr(4'd11, 5'd0, 5'd6, 5'd7, 1'b0, 32'd0, 5'd3, 1'b0, 16'h0000);
        // Masked VXOR, elements 0 and 2 only
        run_instr(4'd8, 5'd4, 5'd1, 5'd2, 1'b0, 32'd0, 5'd4, 1'b1, 16'h0005);
        // Illegal opcode, zero length, over-length clamp
        run_instr(4'd15, 5'd8, 5'd1, 5'd2, 1'b0, 32'd0, 5'd4, 1'b0, 16'h0000);
        run_instr(4'd0, 5'd8, 5'd1, 5'd2, 1'b0, 32'd0, 5'd0, 1'b0, 16'h0000);
        run_instr(4'd1, 5'd9, 5'd10, 5'd11, 1'b0, 32'd0, 5'd20, 1'b0, 16'h0000);

        // Reset during element 2 of an 8-element VMUL
        instr_valid = 1'b1; instr_op = 4'd4; instr_vd = 5'd12; instr_vs1 = 5'd13; instr_vs2 = 5'd14;
        instr_use_scalar = 1'b0; instr_vl = 5'd8; instr_masked = 1'b0;
        a = cyc;
        for (int i = 0; i < 2; i++)
            wr_q.push_back('{addr: {5'd12, 4'(i)}, data: ref_val(4'd4, rf_mem[13][i], rf_mem[14][i]), cyc: a + 2 + i});
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("abort_strobes", {rf_rd_en, rf_wr_en, pred_wr_en, done, illegal}, 5'd0);
        chk("abort_ready", instr_ready, 1'b1);
        chk("abort_wr_data", rf_wr_data, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        chk("abort_writes_outstanding", wr_q.size(), 0);
        run_instr(4'd0, 5'd15, 5'd1, 5'd2, 1'b0, 32'd0, 5'd1, 1'b0, 16'h0000);

        // Randomized instruction stream, issued back to back
        for (int n = 0; n < 40; n++) begin
            run_instr(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                      5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
- Instruction-side driver for the vector lane ALU.
- Accepts one vector arithmetic instruction via valid/ready.
- Steps through elements 0..VL-1, one element per cycle. For each element it reads operands from the synchronous vector register file, drives every ALU control field, and writes the ALU result or predicate back.
- Sits between the coprocessor instruction queue and the ALU/register-file datapath.

Parameters:
- WIDTH, 32, element/data width.
- REG_W, 5, vector register index width (32 registers).
- MAX_VL, 16, elements per vector register; IDX_W = clog2(MAX_VL).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instr_op  in  4  opcode (see Behaviour).
- instr_vd / instr_vs1 / instr_vs2  in  REG_W each  destination / operand-A / operand-B registers.
- instr_use_scalar  in  1  operand B taken from scalar instead of vs2.
- instr_scalar  in  WIDTH  scalar operand.
- instr_vl  in  IDX_W+1  vector length.
- instr_masked  in  1  honour mask.
- instr_mask  in  MAX_VL  element enables.
- rf_rd_en  out  1  register-file read strobe.
- rf_rd_addr_a / rf_rd_addr_b  out  REG_W+IDX_W  read addresses {reg, idx}.
- alu_c  out  WIDTH  latched scalar to ALU C.
- alu_mux_control  out  1  ALU B/C select.
- alu_add_sub  out  1  0 add, 1 subtract.
- alu_output_control  out  3  ALU result select.
- alu_bitwise_control  out  2  bitwise op select.
- alu_comp_control  out  2  comparison op select.
- alu_result  in  WIDTH  ALU finalResult.
- alu_predicate  in  1  ALU predicate.
- rf_wr_en  out  1  result write strobe.
- rf_wr_addr  out  REG_W+IDX_W  write address.
- rf_wr_data  out  WIDTH  write data.
- pred_wr_en  out  1  predicate write strobe.
- pred_wr_idx  out  IDX_W  predicate element index.
- pred_wr_bit  out  1  predicate value.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle illegal-opcode pulse.

Behaviour:
- Reset: state IDLE; instr_ready=1. All strobes, done, illegal, alu_* controls, alu_c, addresses and write data are 0.
- Reset asserted mid-instruction aborts it: no further writes, no done pulse.
- Opcode decode, as output_control / add_sub / bitwise / comp:
  - 0 VADD 000/0; 1 VSUB 000/1; 2 VFADD 001/0; 3 VFSUB 001/1; 4 VMUL 010; 5 VFMUL 011.
  - 6..9 VBIT0..3: output 100, bitwise = op-6.
  - 10..13 VCMP0..3: comp = op-10; predicate-only, no rf write.
  - 14, 15 illegal.
  - Unused fields are 0.
- alu_mux_control = instr_use_scalar.
- Accept occurs when instr_valid && instr_ready (IDLE only). On accept: latch all instr_* fields (mask included). From the next cycle, ALU controls and alu_c hold stable until the cycle after done.
- Illegal opcode: accepted; illegal=1 for 1 cycle (cycle A+1); no reads or writes; returns to IDLE with ready=1 at A+2.
- Length clamp: vl_eff = min(instr_vl, MAX_VL).
- vl_eff=0: done pulse at A+1, no reads or writes, ready at A+2.
- States: IDLE -> ISSUE -> DRAIN -> IDLE.
- ISSUE (cycles A+1 .. A+vl_eff): rf_rd_en=1, idx = 0..vl_eff-1, rd_addr_a={vs1,idx}, rd_addr_b={vs2,idx}. rf_rd_en is asserted even when use_scalar=1.
- Write-back for element i occurs at cycle A+2+i, with the register-file read latency fixed at 1 and the ALU combinational.
  - Arithmetic/bitwise ops: rf_wr_en=1, rf_wr_addr={vd,i}, rf_wr_data=alu_result.
  - Compare ops: pred_wr_en=1, pred_wr_idx=i, pred_wr_bit=alu_predicate; rf_wr_en stays 0.
  - Masked op with mask[i]=0: the read still issues but the write strobe is suppressed.
- DRAIN covers the final write cycle (A+1+vl_eff). done=1 in that same cycle. instr_ready=1 the following cycle, so back-to-back instructions are spaced vl_eff+2 cycles apart.
- instr_ready=0 in ISSUE and DRAIN; instr_valid in those states is ignored.
- Element index never wraps: the counter stops at vl_eff-1, including when vl_eff=MAX_VL.

Test Plan:
- VADD vd=3 vs1=1 vs2=2 vl=4, RF v1=[1,2,3,4] v2=[10,20,30,40] -> writes {3,0..3} = 11,22,33,44 at A+2..A+5; done at A+5; ready at A+6.
- VFSUB use_scalar=1 scalar=0x3F800000 vl=2 -> alu_mux_control=1, alu_add_sub=1, output 001, alu_c=0x3F800000 stable throughout; 2 writes.
- VCMP1 vl=3 with predicate model returning 1,0,1 -> pred_wr_en for idx 0..2 with bits 1,0,1; rf_wr_en never asserted.
- VXOR (op 8) masked, mask=0b0101, vl=4 -> bitwise=10; writes only idx 0 and 2; done at A+5.
- op=15 -> illegal pulse at A+1, no strobes, ready at A+2. Separately, vl=0 -> done at A+1. Separately, vl=20 -> clamped to 16 writes.
- Reset asserted at element 2 of a vl=8 VMUL -> next cycle all strobes 0, ready=1, no done; a following VADD vl=1 completes normally.
